// File: rtl/uart_parity.sv
// uart_parity
//   Combined UART parity generator and checker. One instance serves both
//   TX parity insertion (d_in -> p_out) and RX parity verification
//   (chk_d_in/p_in -> err_*). Both paths share par_mode.
//
//   Optional feature macro: PARITY_ERR_CNT_EN adds the err_cnt port, a
//   16-bit saturating mismatch counter.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   par_mode     00 even, 01 odd, 10 mark (1), 11 space (0)
//   d_in         generator data          -> p_out (combinational)
//   chk_d_in     received data
//   p_in         received parity bit
//   chk_valid    received character present this cycle
//   err_data     combinational mismatch, independent of chk_valid
//   err_valid    registered: a checked character completed last cycle
//   err_flag     registered mismatch of that character (holds otherwise)
//   err_sticky   set on any checked mismatch, cleared by err_clr
//   err_clr      synchronous clear of err_sticky (and err_cnt)
//   err_cnt      saturating mismatch count (PARITY_ERR_CNT_EN only)
module uart_parity #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       par_mode,
  input  logic [WIDTH-1:0] d_in,
  output logic             p_out,
  input  logic [WIDTH-1:0] chk_d_in,
  input  logic             p_in,
  input  logic             chk_valid,
  output logic             err_data,
  output logic             err_valid,
  output logic             err_flag,
  output logic             err_sticky,
  input  logic             err_clr
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam logic [1:0] MODE_EVEN  = 2'b00;
  localparam logic [1:0] MODE_ODD   = 2'b01;
  localparam logic [1:0] MODE_MARK  = 2'b10;

  function automatic logic exp_par(input logic [1:0] mode,
                                   input logic [WIDTH-1:0] x);
    logic r;
    case (mode)
      MODE_EVEN: r = ^x;
      MODE_ODD:  r = ~(^x);
      MODE_MARK: r = 1'b1;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  assign p_out    = exp_par(par_mode, d_in);
  assign err_data = (p_in != exp_par(par_mode, chk_d_in));

  // A mismatch that is actually being checked this cycle.
  logic hit;
  assign hit = chk_valid & err_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid  <= 1'b0;
      err_flag   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_valid <= chk_valid;
      if (chk_valid) err_flag <= err_data;
      // New error beats a simultaneous clear.
      if (hit)          err_sticky <= 1'b1;
      else if (err_clr) err_sticky <= 1'b0;
    end
  end

`ifdef PARITY_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (hit) begin
      // Clear and error together leave a count of exactly one.
      if (err_clr)                err_cnt <= 16'd1;
      else if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end else if (err_clr) begin
      err_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_parity.sv
module tb_uart_parity;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] par_mode;
  logic [7:0] d_in;
  logic       p_out;
  logic [7:0] chk_d_in;
  logic       p_in;
  logic       chk_valid;
  logic       err_data;
  logic       err_valid;
  logic       err_flag;
  logic       err_sticky;
  logic       err_clr;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_parity #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .par_mode(par_mode), .d_in(d_in), .p_out(p_out),
    .chk_d_in(chk_d_in), .p_in(p_in), .chk_valid(chk_valid),
    .err_data(err_data), .err_valid(err_valid), .err_flag(err_flag),
    .err_sticky(err_sticky), .err_clr(err_clr)
`ifdef PARITY_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] d;
    logic [7:0] cd;
    logic       pi;
    logic       exp_p;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference parity by counting ones bit by bit.
  function automatic logic ref_par(input logic [1:0] mode, input logic [7:0] x);
    int ones = 0;
    for (int b = 0; b < 8; b++) if (x[b]) ones++;
    case (mode)
      2'b00: return (ones % 2) == 1;
      2'b01: return (ones % 2) == 0;
      2'b10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[12];

  initial begin
    vt[0]  = '{2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{2'b00, 8'h24, 8'h24, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{2'b00, 8'h25, 8'h25, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{2'b00, 8'h26, 8'h25, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{2'b00, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};
    vt[5]  = '{2'b01, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[6]  = '{2'b01, 8'h07, 8'h07, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{2'b10, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1};
    vt[8]  = '{2'b10, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{2'b11, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0};
    vt[10] = '{2'b11, 8'h01, 8'h3C, 1'b0, 1'b0, 1'b0};
    vt[11] = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; par_mode = 2'b00; d_in = '0; chk_d_in = '0; p_in = 1'b0;
    chk_valid = 1'b0; err_clr = 1'b0;
    #12;
    check("reset_err_valid", {15'd0, err_valid}, 16'd0);
    check("reset_err_flag", {15'd0, err_flag}, 16'd0);
    check("reset_err_sticky", {15'd0, err_sticky}, 16'd0);
`ifdef PARITY_ERR_CNT_EN
    check("reset_err_cnt", err_cnt, 16'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Combinational vectors, chk_valid low.
    for (int i = 0; i < 12; i++) begin
      par_mode = vt[i].mode; d_in = vt[i].d; chk_d_in = vt[i].cd; p_in = vt[i].pi;
      #1;
      check($sformatf("vec%0d_p_out", i), {15'd0, p_out}, {15'd0, vt[i].exp_p});
      check($sformatf("vec%0d_err_data", i), {15'd0, err_data}, {15'd0, vt[i].exp_err});
    end
    tick();
    check("no_valid_sticky", {15'd0, err_sticky}, 16'd0);

    // Loopback in every mode, checked every cycle.
    for (int m = 0; m < 4; m++) begin
      int bad = 0;
      int badp = 0;
      par_mode = m[1:0];
      for (int i = 0; i < 256; i++) begin
        logic [7:0] v;
        if (i % 3 == 0)      v = i[7:0];
        else if (i % 3 == 1) v = 8'(255 - i);
        else                 v = 8'($urandom);
        d_in = v; chk_d_in = v; chk_valid = 1'b1;
        #1;
        p_in = p_out;
        #1;
        if (err_data !== 1'b0) bad++;
        if (p_out !== ref_par(m[1:0], v)) badp++;
        tick();
      end
      chk_valid = 1'b0;
      check($sformatf("loop_m%0d_err_data", m), bad[15:0], 16'd0);
      check($sformatf("loop_m%0d_p_out", m), badp[15:0], 16'd0);
      check($sformatf("loop_m%0d_sticky", m), {15'd0, err_sticky}, 16'd0);
      check($sformatf("loop_m%0d_err_valid", m), {15'd0, err_valid}, 16'd1);
      check($sformatf("loop_m%0d_err_flag", m), {15'd0, err_flag}, 16'd0);
    end
    tick();

    // Odd-mode single erroring character.
    par_mode = 2'b01; chk_d_in = 8'h00; p_in = 1'b0; chk_valid = 1'b1;
    #1;
    check("odd_err_data", {15'd0, err_data}, 16'd1);
    check("odd_pre_err_valid", {15'd0, err_valid}, 16'd0);
    tick();
    chk_valid = 1'b0;
    check("odd_err_valid", {15'd0, err_valid}, 16'd1);
    check("odd_err_flag", {15'd0, err_flag}, 16'd1);
    check("odd_err_sticky", {15'd0, err_sticky}, 16'd1);
    tick();
    check("odd_err_valid_drop", {15'd0, err_valid}, 16'd0);
    check("odd_err_flag_hold", {15'd0, err_flag}, 16'd1);

    // Clear alone drops sticky.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("clr_alone", {15'd0, err_sticky}, 16'd0);

    // Clear coincident with an error: set wins; then clear alone.
    par_mode = 2'b10; p_in = 1'b0; chk_valid = 1'b1; err_clr = 1'b1;
    tick();
    chk_valid = 1'b0;
    check("clr_vs_err_sticky", {15'd0, err_sticky}, 16'd1);
    tick();
    err_clr = 1'b0;
    check("clr_next_sticky", {15'd0, err_sticky}, 16'd0);

    // Good character after an error updates err_flag to 0.
    par_mode = 2'b11; p_in = 1'b0; chk_valid = 1'b1;
    tick();
    chk_valid = 1'b0;
    check("good_flag", {15'd0, err_flag}, 16'd0);
    check("good_sticky", {15'd0, err_sticky}, 16'd0);

`ifdef PARITY_ERR_CNT_EN
    // Counter: clear first, then three errors.
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    par_mode = 2'b10; p_in = 1'b0; chk_valid = 1'b1;
    repeat (3) tick();
    chk_valid = 1'b0;
    check("cnt_three", err_cnt, 16'd3);
    chk_valid = 1'b1; err_clr = 1'b1; tick();
    chk_valid = 1'b0; err_clr = 1'b0;
    check("cnt_clr_and_err", err_cnt, 16'd1);
`endif

    // Asynchronous reset mid-stream with chk_valid held erroring.
    par_mode = 2'b10; p_in = 1'b0; chk_valid = 1'b1;
    tick();
    check("pre_rst_sticky", {15'd0, err_sticky}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_err_valid", {15'd0, err_valid}, 16'd0);
    check("arst_err_flag", {15'd0, err_flag}, 16'd0);
    check("arst_err_sticky", {15'd0, err_sticky}, 16'd0);
`ifdef PARITY_ERR_CNT_EN
    check("arst_err_cnt", err_cnt, 16'd0);
`endif
    check("arst_err_data_comb", {15'd0, err_data}, 16'd1);
    tick();
    check("rst_discard_valid", {15'd0, err_valid}, 16'd0);
    check("rst_discard_sticky", {15'd0, err_sticky}, 16'd0);
    chk_valid = 1'b0;
    rst_n = 1'b1;
    tick();

`ifdef PARITY_ERR_CNT_EN
    // Saturation.
    chk_valid = 1'b1;
    repeat (65537) tick();
    check("cnt_sat", err_cnt, 16'hFFFF);
    tick();
    chk_valid = 1'b0;
    check("cnt_sat_hold", err_cnt, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
